// File: rtl/quant_pkg.sv
// Shared types, constants and arithmetic helpers for the quantizing sequencer.
package quant_pkg;

  typedef enum logic [1:0] {
    QM_INT8 = 2'd0,
    QM_INT4 = 2'd1,
    QM_BIN  = 2'd2
  } qmode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAL    = 3'd1,
    ST_SEARCH = 3'd2,
    ST_QUANT  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } qseq_state_e;

  localparam logic [31:0] QMAX_INT8 = 32'd127;
  localparam logic [31:0] QMAX_INT4 = 32'd7;

  // Encoding 3 is reserved and behaves as INT8.
  function automatic qmode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return QM_INT4;
      2'd2:    return QM_BIN;
      default: return QM_INT8;
    endcase
  endfunction

  // Round-half-up right shift of an unsigned magnitude.
  function automatic logic [31:0] round_shift(input logic [31:0] mag, input logic [4:0] sh);
    if (sh == 5'd0) return mag;
    return (mag + (32'd1 << (sh - 5'd1))) >> sh;
  endfunction

endpackage

// File: rtl/quantizer_unit.sv
// Combinational quantizer: sign-magnitude rounding shift with symmetric saturation
// to INT8 / INT4, plus a sign bit for binary mode (1 = non-negative).
module quantizer_unit
  import quant_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic [IN_W-1:0] data,
  input  logic [4:0]      shift,
  output logic [7:0]      q8,
  output logic [3:0]      q4,
  output logic            qb
);

  logic            neg;
  logic [IN_W:0]   mag;
  logic [31:0]     rnd;
  logic [6:0]      mag8;
  logic [2:0]      mag4;

  // Rounding is applied to the magnitude so that ties go away from zero.
  always_comb begin
    neg  = data[IN_W-1];
    mag  = neg ? ({1'b0, ~data} + (IN_W+1)'(1)) : {1'b0, data};
    rnd  = round_shift(32'(mag), shift);
    mag8 = (rnd > QMAX_INT8) ? 7'd127 : rnd[6:0];
    mag4 = (rnd > QMAX_INT4) ? 3'd7 : rnd[2:0];
    q8   = neg ? (8'd0 - {1'b0, mag8}) : {1'b0, mag8};
    q4   = neg ? (4'd0 - {1'b0, mag4}) : {1'b0, mag4};
    qb   = ~neg;
  end

endmodule

// File: rtl/quant_sequencer.sv
// Streams one tensor through quantizer_unit and packs INT8 / INT4 / binary bytes.
// Optional calibration pass (max-abs + shift search) built when QSEQ_AUTO_SHIFT_EN is defined.
module quant_sequencer
  import quant_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             auto_shift,
  input  logic [4:0]       shift_cfg,
  output logic             rd_en,
  output logic [LEN_W-1:0] rd_addr,
  input  logic [IN_W-1:0]  rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [4:0]       shift_used,
  output qseq_state_e      fsm_state
);

  // Handshake: a byte transfers on a cycle where out_valid && out_ready. While
  // out_valid && !out_ready the byte and out_last are frozen and no read is issued;
  // a read already in flight is parked in the holding register.

  qseq_state_e      state, state_nx;
  qmode_e           mode_dec, mode_q;
  logic [LEN_W-1:0] len_q, cons_cnt;
  logic             rd_pending, hold_valid;
  logic [IN_W-1:0]  hold_data, elem_data;
  logic [7:0]       pack_reg, packed_byte, base_byte, load_data;
  logic [3:0]       pack_cnt, per_byte_m1;
  logic             out_free, elem_avail, consume, byte_full, last_elem, last_accept;
  logic             flush_load, load, load_last;
  logic [7:0]       q8;
  logic [3:0]       q4;
  logic             qb;

`ifdef QSEQ_AUTO_SHIFT_EN
  logic [IN_W:0]    maxabs, rd_abs;
  logic [4:0]       cand;
  logic [31:0]      search_rnd, qmax;
  logic             search_pass, go_cal;

  // maxabs is one bit wider so the most negative input is represented exactly.
  always_comb begin
    rd_abs      = rd_data[IN_W-1] ? ({1'b0, ~rd_data} + (IN_W+1)'(1)) : {1'b0, rd_data};
    search_rnd  = round_shift(32'(maxabs), cand);
    qmax        = (mode_q == QM_INT4) ? QMAX_INT4 : QMAX_INT8;
    search_pass = (search_rnd <= qmax) || (cand >= 5'(IN_W));
    go_cal      = auto_shift && (mode_dec != QM_BIN);
  end
`else
  logic unused_auto_shift;
  assign unused_auto_shift = auto_shift;
`endif

  assign elem_data = hold_valid ? hold_data : rd_data;

  quantizer_unit #(.IN_W(IN_W)) u_quant (
    .data  (elem_data),
    .shift (shift_used),
    .q8    (q8),
    .q4    (q4),
    .qb    (qb)
  );

  always_comb begin
    mode_dec    = decode_mode(mode);
    out_free    = !out_valid || out_ready;
    last_accept = out_valid && out_ready && out_last;
    rd_en       = 1'b0;
    if (state == ST_QUANT) rd_en = (rd_addr < len_q) && out_free;
`ifdef QSEQ_AUTO_SHIFT_EN
    if (state == ST_CAL) rd_en = (rd_addr < len_q);
`endif
    elem_avail = (state == ST_QUANT) && (hold_valid || rd_pending);
    consume    = elem_avail && out_free;
    busy       = (state != ST_IDLE);
    fsm_state  = state;
  end

  always_comb begin
    case (mode_q)
      QM_INT4: per_byte_m1 = 4'd1;
      QM_BIN:  per_byte_m1 = 4'd7;
      default: per_byte_m1 = 4'd0;
    endcase
    byte_full = (pack_cnt == per_byte_m1);
    last_elem = (cons_cnt == (len_q - LEN_W'(1)));
    // Starting a fresh byte clears stale bits so a flushed partial byte is zero-filled.
    base_byte = (pack_cnt == 4'd0) ? 8'h00 : pack_reg;
    case (mode_q)
      QM_INT4: packed_byte = pack_cnt[0] ? {q4, base_byte[3:0]} : {4'h0, q4};
      QM_BIN:  packed_byte = base_byte | (8'(qb) << pack_cnt[2:0]);
      default: packed_byte = q8;
    endcase
    flush_load = (state == ST_FLUSH) && (pack_cnt != 4'd0) && out_free;
    load       = (consume && byte_full) || flush_load;
    load_data  = flush_load ? pack_reg : packed_byte;
    load_last  = flush_load || last_elem;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) state_nx = ST_DONE;
`ifdef QSEQ_AUTO_SHIFT_EN
          else if (go_cal) state_nx = ST_CAL;
`endif
          else state_nx = ST_QUANT;
        end
      end
`ifdef QSEQ_AUTO_SHIFT_EN
      ST_CAL:    if (rd_addr == len_q) state_nx = ST_SEARCH;
      ST_SEARCH: if (search_pass) state_nx = ST_QUANT;
`endif
      ST_QUANT: begin
        if (last_accept) state_nx = ST_DONE;
        else if (consume && last_elem && !byte_full) state_nx = ST_FLUSH;
      end
      ST_FLUSH: if (last_accept) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= QM_INT8;
      len_q      <= '0;
      rd_addr    <= '0;
      cons_cnt   <= '0;
      rd_pending <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      pack_reg   <= '0;
      pack_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      shift_used <= '0;
`ifdef QSEQ_AUTO_SHIFT_EN
      maxabs     <= '0;
      cand       <= '0;
`endif
    end else begin
      state      <= state_nx;
      done       <= (state == ST_DONE);
      rd_pending <= rd_en;
      if (rd_en) rd_addr <= rd_addr + LEN_W'(1);

      if (state == ST_IDLE && start) begin
        mode_q     <= mode_dec;
        len_q      <= len;
        rd_addr    <= '0;
        cons_cnt   <= '0;
        pack_cnt   <= '0;
        pack_reg   <= '0;
        hold_valid <= 1'b0;
        if (state_nx == ST_QUANT) shift_used <= (mode_dec == QM_BIN) ? 5'd0 : shift_cfg;
`ifdef QSEQ_AUTO_SHIFT_EN
        maxabs     <= '0;
        cand       <= '0;
`endif
      end

`ifdef QSEQ_AUTO_SHIFT_EN
      if (state == ST_CAL) begin
        if (rd_pending && (rd_abs > maxabs)) maxabs <= rd_abs;
        if (state_nx == ST_SEARCH) rd_addr <= '0;
      end
      if (state == ST_SEARCH) begin
        if (search_pass) shift_used <= cand;
        else cand <= cand + 5'd1;
      end
`endif

      if (state == ST_QUANT && rd_pending && !out_free) begin
        hold_valid <= 1'b1;
        hold_data  <= rd_data;
      end else if (consume && hold_valid) begin
        hold_valid <= 1'b0;
      end

      if (consume) begin
        cons_cnt <= cons_cnt + LEN_W'(1);
        if (byte_full) begin
          pack_cnt <= 4'd0;
        end else begin
          pack_reg <= packed_byte;
          pack_cnt <= pack_cnt + 4'd1;
        end
      end
      if (flush_load) pack_cnt <= 4'd0;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_last  <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quant_sequencer.sv
// Directed bench for quant_sequencer: byte scoreboard, read counting, stall and reset checks.
module tb_quant_sequencer;
  import quant_pkg::*;

  localparam int IN_W  = 16;
  localparam int LEN_W = 12;
`ifdef QSEQ_AUTO_SHIFT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, auto_shift, out_ready;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len, rd_addr;
  logic [4:0]       shift_cfg, shift_used;
  logic             rd_en, out_valid, out_last, busy, done;
  logic [IN_W-1:0]  rd_data;
  logic [7:0]       out_data;
  qseq_state_e      fsm_state;

  logic [IN_W-1:0]  mem [0:63];
  logic [8:0]       exp_q[$];
  int               tests = 0;
  int               fails = 0;
  int               rd_cnt = 0;
  logic             stalled_prev = 1'b0;
  logic [8:0]       prev_byte = '0;
  int               dcyc;

  always #5 clk = ~clk;

  quant_sequencer #(.IN_W(IN_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
    .auto_shift(auto_shift), .shift_cfg(shift_cfg), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .shift_used(shift_used),
    .fsm_state(fsm_state)
  );

  // 1-cycle-latency activation buffer
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_q8(input int v, input int s);
    int m, r;
    m = (v < 0) ? -v : v;
    r = (s == 0) ? m : (m + (1 << (s - 1))) / (1 << s);
    if (r > 127) r = 127;
    return 8'((v < 0) ? -r : r);
  endfunction

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (rd_en) rd_cnt++;
      if (stalled_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_byte_held", {out_last, out_data}, prev_byte);
      end
      if (out_valid && !out_ready) check("no_rd_in_stall", rd_en, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_byte: observed %0h expected none", {out_last, out_data});
        end else begin
          check("byte", {out_last, out_data}, exp_q.pop_front());
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_byte    = {out_last, out_data};
    end
  end

  task automatic run_job(input logic [1:0] m, input int n, input logic a, input logic [4:0] sc,
                         input int stall_at, input int exp_shift, input int exp_reads,
                         output int done_cyc);
    int cyc;
    bit got;
    @(posedge clk); #1;
    rd_cnt = 0;
    start = 1'b1; mode = m; len = LEN_W'(n); auto_shift = a; shift_cfg = sc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_rd_en", rd_en, (n != 0));
    cyc = 1; got = 1'b0; done_cyc = -1;
    while (!got && cyc < 400) begin
      if (cyc == stall_at) out_ready = 1'b0;
      if (cyc == stall_at + 5) out_ready = 1'b1;
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
        check("busy_with_done", busy, 0);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    out_ready = 1'b1;
    check("done_seen", got, 1);
    if (got) begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
    end
    check("bytes_left", 32'(exp_q.size()), 0);
    check("rd_count", 32'(rd_cnt), 32'(exp_reads));
    if (exp_shift >= 0) check("shift_used", shift_used, 32'(exp_shift));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; len = '0; auto_shift = 1'b0;
    shift_cfg = 5'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_shift_used", shift_used, 0);
    rst = 1'b0;

    // INT8 auto: shift 3 either way (shift_cfg matches the calibrated value)
    mem[0] = 16'd1000; mem[1] = 16'(-300); mem[2] = 16'd50; mem[3] = 16'd0;
    exp_q.push_back(9'h07D); exp_q.push_back(9'h0DA);
    exp_q.push_back(9'h006); exp_q.push_back(9'h100);
    run_job(2'd0, 4, 1'b1, 5'd3, -1, 3, AUTO ? 8 : 4, dcyc);

    // INT4 manual, odd length -> flushed partial byte
    mem[0] = 16'd3; mem[1] = 16'(-2); mem[2] = 16'd9;
    exp_q.push_back(9'h0E3); exp_q.push_back(9'h107);
    run_job(2'd1, 3, 1'b0, 5'd0, -1, 0, 3, dcyc);

    // BIN with auto requested: forced shift 0, no calibration reads
    for (int i = 0; i < 10; i++) mem[i] = (i % 2 == 0) ? 16'd5 : 16'(-5);
    exp_q.push_back(9'h055); exp_q.push_back(9'h101);
    run_job(2'd2, 10, 1'b1, 5'd5, -1, 0, 10, dcyc);

    // Most negative input with auto shift
    mem[0] = 16'h8000;
    exp_q.push_back(AUTO ? 9'h1C0 : 9'h181);
    run_job(2'd0, 1, 1'b1, 5'd0, -1, AUTO ? 9 : 0, AUTO ? 2 : 1, dcyc);

    // Back-pressure: ready low for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'(i * 80 - 300);
      exp_q.push_back({(i == 7), ref_q8(i * 80 - 300, 2)});
    end
    run_job(2'd0, 8, 1'b0, 5'd2, 5, 2, 8, dcyc);

    // Mode 3 behaves as INT8
    mem[0] = 16'd20; mem[1] = 16'(-20);
    exp_q.push_back(9'h00A); exp_q.push_back(9'h1F6);
    run_job(2'd3, 2, 1'b0, 5'd1, -1, 1, 2, dcyc);

    // Empty job
    run_job(2'd0, 0, 1'b0, 5'd0, -1, -1, 0, dcyc);
    check("len0_done_cycle", 32'(dcyc), 2);

    // Reset during QUANT
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'(10 + i);
      exp_q.push_back({(i == 7), 8'(10 + i)});
    end
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; len = LEN_W'(8); auto_shift = 1'b0; shift_cfg = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_shift_used", shift_used, 0);
    rst = 1'b0;
    exp_q.delete();

    // Clean job after reset
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'(-3); mem[3] = 16'd4;
    exp_q.push_back(9'h021); exp_q.push_back(9'h14D);
    run_job(2'd1, 4, 1'b0, 5'd0, -1, 0, 4, dcyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
